bist_controller: RTL

- Sequencing FSM for the BIST wrapper around the sync-detector CUT (in_k/in_j/in_en -> synced_d/sync_err_d).
- On a bist_start rising edge it:
  - initialises the LFSR pattern generator and the MISR compactor;
  - switches CUT inputs to LFSR patterns for N_PATTERNS cycles;
  - compares the final MISR signature with a golden constant.
- Drives bist_end and pass_fail to the top level and returns the CUT to functional mode.

---
 rtl/bist_pkg.sv | 55 +++++
 rtl/bist_controller_if.sv | 25 ++
 rtl/bist_edge_det.sv | 24 ++
 rtl/bist_controller.sv | 123 ++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared constants for the BIST wrapper: FSM encodings, output bundle and generator/compactor seeds.
// The BIST_SETTLE_EN macro adds the SETTLE state decode.
package bist_pkg;

    localparam int DEFAULT_SIG_W = 16;
    localparam int SETTLE_CYC    = 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] MISR_SEED = 16'h0000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_COMPARE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef struct packed {
        logic test_mode;
        logic cut_rst;
        logic lfsr_init;
        logic lfsr_en;
        logic misr_init;
        logic misr_en;
    } ctrl_t;

    // Strobe pattern that goes with each state; registered by the controller.
    function automatic ctrl_t state_ctrl(input logic [2:0] st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_INIT: begin
                c.test_mode = 1'b1;
                c.cut_rst   = 1'b1;
                c.lfsr_init = 1'b1;
                c.misr_init = 1'b1;
            end
            ST_RUN: begin
                c.test_mode = 1'b1;
                c.lfsr_en   = 1'b1;
                c.misr_en   = 1'b1;
            end
`ifdef BIST_SETTLE_EN
            ST_SETTLE: begin
                c.test_mode = 1'b1;
                c.misr_en   = 1'b1;
            end
`endif
            ST_COMPARE: c.test_mode = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bist_controller_if.sv
// Control/status bundle between the BIST controller and the wrapper top level.
interface bist_controller_if #(
    parameter int SIG_W = bist_pkg::DEFAULT_SIG_W
);
    logic             bist_start;
    logic [SIG_W-1:0] signature;
    logic             test_mode;
    logic             cut_rst;
    logic             lfsr_init;
    logic             lfsr_en;
    logic             misr_init;
    logic             misr_en;
    logic             bist_end;
    logic             pass_fail;

    modport master (
        output bist_start, signature,
        input  test_mode, cut_rst, lfsr_init, lfsr_en, misr_init, misr_en, bist_end, pass_fail
    );

    modport slave (
        input  bist_start, signature,
        output test_mode, cut_rst, lfsr_init, lfsr_en, misr_init, misr_en, bist_end, pass_fail
    );
endinterface

// File: rtl/bist_edge_det.sv
// Rising-edge detector for level strobes; a level already high when reset releases is not an edge.
module bist_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic go_o
);
    logic sig_q;
    logic armed_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sig_q   <= sig_i;
            armed_q <= armed_q | ~sig_i;
        end
    end

    assign go_o = sig_i & ~sig_q & armed_q;

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: INIT -> RUN (N_PATTERNS) -> [SETTLE] -> COMPARE -> DONE with registered strobes.
// Define BIST_SETTLE_EN to flush the CUT pipeline into the MISR before the compare.
module bist_controller
    import bist_pkg::*;
#(
    parameter int               N_PATTERNS = 200,
    parameter int               CNT_W      = 8,
    parameter int               SIG_W      = DEFAULT_SIG_W,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input  logic          CLK,
    input  logic          RST_N,
    bist_controller_if.slave bus
);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(N_PATTERNS - 1);
`ifdef BIST_SETTLE_EN
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             end_q, end_d;
    logic             pf_q, pf_d;
    logic             go;
    logic [CNT_W-1:0] cnt_inc;

    bist_edge_det u_start_edge (
        .clk   (CLK),
        .rst_n (RST_N),
        .sig_i (bus.bist_start),
        .go_o  (go)
    );

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        end_d   = end_q;
        pf_d    = pf_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_INIT;
                    end_d   = 1'b0;
                    pf_d    = 1'b0;
                end
            end
            ST_INIT: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    cnt_d = '0;
`ifdef BIST_SETTLE_EN
                    state_d = ST_SETTLE;
`else
                    state_d = ST_COMPARE;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`ifdef BIST_SETTLE_EN
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_COMPARE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            ST_COMPARE: begin
                state_d = ST_DONE;
                end_d   = 1'b1;
                pf_d    = (bus.signature == GOLDEN_SIG);
            end
            ST_DONE: begin
                // A fresh edge while results are shown restarts; holding the request does not.
                if (go) begin
                    state_d = ST_INIT;
                    end_d   = 1'b0;
                    pf_d    = 1'b0;
                end else if (!bus.bist_start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ctrl_d = state_ctrl(state_d);
    end

    // NOTE: only control flops live here, so all of them take the async reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            end_q   <= 1'b0;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            end_q   <= end_d;
            pf_q    <= pf_d;
        end
    end

    assign bus.test_mode = ctrl_q.test_mode;
    assign bus.cut_rst   = ctrl_q.cut_rst;
    assign bus.lfsr_init = ctrl_q.lfsr_init;
    assign bus.lfsr_en   = ctrl_q.lfsr_en;
    assign bus.misr_init = ctrl_q.misr_init;
    assign bus.misr_en   = ctrl_q.misr_en;
    assign bus.bist_end  = end_q;
    assign bus.pass_fail = pf_q;

endmodule
